// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, flag bit positions and legality check shared by the ALU datapath.
package alu_pkg;
    localparam logic [4:0] OP_MOVA = 5'd0;
    localparam logic [4:0] OP_INC  = 5'd1;
    localparam logic [4:0] OP_ADD  = 5'd2;
    localparam logic [4:0] OP_ADDC = 5'd3;
    localparam logic [4:0] OP_SUB  = 5'd4;
    localparam logic [4:0] OP_SUBB = 5'd5;
    localparam logic [4:0] OP_DEC  = 5'd6;
    localparam logic [4:0] OP_NEG  = 5'd7;
    localparam logic [4:0] OP_AND  = 5'd8;
    localparam logic [4:0] OP_OR   = 5'd9;
    localparam logic [4:0] OP_XOR  = 5'd10;
    localparam logic [4:0] OP_NOTA = 5'd11;
    localparam logic [4:0] OP_SHL  = 5'd12;
    localparam logic [4:0] OP_SHR  = 5'd13;
    localparam logic [4:0] OP_ASR  = 5'd14;
    localparam logic [4:0] OP_MOVB = 5'd15;
    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;
    function automatic logic is_legal(input logic [4:0] s);
        return !s[4];
    endfunction
endpackage

// File: rtl/alu_nbit_core.sv
// alu_nbit_core: combinational WIDTH-bit ALU producing result, V/C/N/Z and legality.
module alu_nbit_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [4:0]       s,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] f,
    output logic             v,
    output logic             c,
    output logic             n,
    output logic             z,
    output logic             legal
);
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             ci;
    logic [WIDTH:0]   sum;

    // Every arithmetic op is one adder pass: subtraction is x + ~y + 1, DEC adds all-ones.
    always_comb begin
        x = a;
        y = '0;
        ci = 1'b0;
        case (s)
            OP_INC:  ci = 1'b1;
            OP_ADD:  y = b;
            OP_ADDC: begin y = b; ci = cin; end
            OP_SUB:  begin y = ~b; ci = 1'b1; end
            OP_SUBB: begin y = ~b; ci = cin; end
            OP_DEC:  y = '1;
            OP_NEG:  begin x = '0; y = ~a; ci = 1'b1; end
            default: ;
        endcase
        sum = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, ci};
        f = '0;
        c = 1'b0;
        v = 1'b0;
        case (s)
            OP_MOVA: f = a;
            OP_INC, OP_ADD, OP_ADDC, OP_SUB, OP_SUBB, OP_DEC, OP_NEG: begin
                f = sum[WIDTH-1:0];
                c = sum[WIDTH];
                v = (x[WIDTH-1] == y[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
            end
            OP_AND:  f = a & b;
            OP_OR:   f = a | b;
            OP_XOR:  f = a ^ b;
            OP_NOTA: f = ~a;
            OP_SHL:  begin f = {a[WIDTH-2:0], 1'b0}; c = a[WIDTH-1]; end
            OP_SHR:  begin f = {1'b0, a[WIDTH-1:1]}; c = a[0]; end
            OP_ASR:  begin f = {a[WIDTH-1], a[WIDTH-1:1]}; c = a[0]; end
            OP_MOVB: f = b;
            default: f = '0;
        endcase
        n = f[WIDTH-1];
        z = (f == '0);
        legal = is_legal(s);
    end
endmodule

// File: rtl/alu_regfile_pipe.sv
// alu_regfile_pipe: register file + ALU in a two-stage EX/OUT pipeline with forwarding,
// sticky flags, output backpressure and a registered debug read port.
module alu_regfile_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NREG = 8,
    localparam int AW = $clog2(NREG)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [4:0]       op_s,
    input  logic [AW-1:0]    op_da,
    input  logic [AW-1:0]    op_aa,
    input  logic [AW-1:0]    op_ba,
    input  logic             op_wr,
    input  logic             op_imm_en,
    input  logic [WIDTH-1:0] op_imm,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_illeg,
    output logic             flag_v,
    output logic             flag_c,
    output logic             flag_n,
    output logic             flag_z,
    input  logic [AW-1:0]    dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);
    logic [WIDTH-1:0] regs [NREG];
    logic             ex_valid;
    logic [4:0]       ex_s;
    logic [AW-1:0]    ex_da;
    logic             ex_wr;
    logic [WIDTH-1:0] ex_a;
    logic [WIDTH-1:0] ex_b;
    logic [3:0]       flags;
    logic [WIDTH-1:0] f;
    logic             v, c, n, z, legal;
    logic             retire, accept, hit;
    logic [WIDTH-1:0] fwd_a, fwd_b;

    // Flags only change on retire and ops retire in order, so the live C flag at the
    // retire edge is exactly the carry produced by the preceding op.
    alu_nbit_core #(.WIDTH(WIDTH)) u_core (
        .s(ex_s), .a(ex_a), .b(ex_b), .cin(flags[FLAG_C]),
        .f(f), .v(v), .c(c), .n(n), .z(z), .legal(legal)
    );

    assign retire = ex_valid && (!res_valid || res_ready);
    assign op_ready = !ex_valid || retire;
    assign accept = op_valid && op_ready;
    assign hit = retire && ex_wr && legal;
    assign fwd_a = (hit && ex_da == op_aa) ? f : regs[op_aa];
    assign fwd_b = op_imm_en ? op_imm : (hit && ex_da == op_ba) ? f : regs[op_ba];
    assign {flag_v, flag_c, flag_n, flag_z} = {flags[FLAG_V], flags[FLAG_C], flags[FLAG_N], flags[FLAG_Z]};

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
            flags <= '0;
            ex_valid <= 1'b0;
            res_valid <= 1'b0;
            res_data <= '0;
            res_illeg <= 1'b0;
            dbg_data <= '0;
        end else begin
            if (accept) begin
                ex_valid <= 1'b1;
                ex_s <= op_s;
                ex_da <= op_da;
                ex_wr <= op_wr;
                ex_a <= fwd_a;
                ex_b <= fwd_b;
            end else if (retire) begin
                ex_valid <= 1'b0;
            end
            if (retire) begin
                res_valid <= 1'b1;
                res_data <= f;
                res_illeg <= !legal;
                if (ex_wr && legal) regs[ex_da] <= f;
                if (legal) begin
                    flags[FLAG_V] <= v;
                    flags[FLAG_C] <= c;
                    flags[FLAG_N] <= n;
                    flags[FLAG_Z] <= z;
                end
            end else if (res_ready) begin
                res_valid <= 1'b0;
            end
            dbg_data <= regs[dbg_addr];
        end
    end
endmodule

// File: tb/tb_alu_regfile_pipe.sv
// tb_alu_regfile_pipe: directed scenarios plus randomized ops against an in-order
// architectural model (each accepted op executes immediately on the model's registers).
module tb_alu_regfile_pipe;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        op_valid = 1'b0, op_ready;
    logic [4:0]  op_s = '0;
    logic [2:0]  op_da = '0, op_aa = '0, op_ba = '0;
    logic        op_wr = 1'b0, op_imm_en = 1'b0;
    logic [15:0] op_imm = '0;
    logic        res_valid, res_ready = 1'b1;
    logic [15:0] res_data;
    logic        res_illeg;
    logic        flag_v, flag_c, flag_n, flag_z;
    logic [2:0]  dbg_addr = '0;
    logic [15:0] dbg_data;

    typedef struct packed {logic [15:0] d; logic i; logic [3:0] fl;} res_t;
    res_t pend_q[$], done_q[$], obs_q[$];
    int   mr[8];
    logic [3:0] mf;
    int   total = 0, bad = 0;

    always #5 clock = ~clock;

    alu_regfile_pipe #(.WIDTH(16), .NREG(8)) dut (
        .clock(clock), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
        .op_s(op_s), .op_da(op_da), .op_aa(op_aa), .op_ba(op_ba), .op_wr(op_wr),
        .op_imm_en(op_imm_en), .op_imm(op_imm), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_illeg(res_illeg), .flag_v(flag_v), .flag_c(flag_c),
        .flag_n(flag_n), .flag_z(flag_z), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    // Architectural semantics in plain integer arithmetic; flags packed {V,C,N,Z}.
    function automatic res_t model_exec(input int s, input int a, input int b);
        int sa, sb, full, sres, f, bw;
        logic v, c;
        bit arith;
        sa = a >= 32768 ? a - 65536 : a;
        sb = b >= 32768 ? b - 65536 : b;
        v = 0; c = 0; f = 0; arith = 1; full = 0; sres = 0;
        bw = mf[2] ? 0 : 1;
        case (s)
            1: begin full = a + 1; sres = sa + 1; c = full > 65535; end
            2: begin full = a + b; sres = sa + sb; c = full > 65535; end
            3: begin full = a + b + (1 - bw); sres = sa + sb + (1 - bw); c = full > 65535; end
            4: begin full = a - b; sres = sa - sb; c = a >= b; end
            5: begin full = a - b - bw; sres = sa - sb - bw; c = a >= b + bw; end
            6: begin full = a - 1; sres = sa - 1; c = a >= 1; end
            7: begin full = -a; sres = -sa; c = a == 0; end
            default: arith = 0;
        endcase
        if (arith) begin
            f = full & 32'hFFFF;
            v = sres < -32768 || sres > 32767;
        end else begin
            case (s)
                0: f = a;
                8: f = a & b;
                9: f = a | b;
                10: f = a ^ b;
                11: f = (~a) & 32'hFFFF;
                12: begin f = (a * 2) & 32'hFFFF; c = a >= 32768; end
                13: begin f = a / 2; c = a[0]; end
                14: begin f = (sa >>> 1) & 32'hFFFF; c = a[0]; end
                15: f = b;
                default: f = 0;
            endcase
        end
        if (s >= 16) return '{16'h0000, 1'b1, mf};
        mf = {v, c, f >= 32768, f == 0};
        return '{f[15:0], 1'b0, mf};
    endfunction

    task automatic step(input bit v, input int s, input int da, input int aa, input int ba,
                        input bit wr, input bit ie, input int imm, input bit rr, output bit acc);
        res_t e;
        int a, b;
        op_valid = v; op_s = s[4:0]; op_da = da[2:0]; op_aa = aa[2:0]; op_ba = ba[2:0];
        op_wr = wr; op_imm_en = ie; op_imm = imm[15:0]; res_ready = rr;
        #1;
        acc = op_valid && op_ready;
        if (res_valid && res_ready) begin
            obs_q.push_back('{res_data, res_illeg, {flag_v, flag_c, flag_n, flag_z}});
            done_q.push_back(pend_q.size() > 0 ? pend_q.pop_front() : res_t'('x));
        end
        if (acc) begin
            a = mr[aa];
            b = ie ? (imm & 32'hFFFF) : mr[ba];
            e = model_exec(s, a, b);
            if (!e.i && wr) mr[da] = int'(e.d);
            pend_q.push_back(e);
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic drain();
        bit acc;
        for (int k = 0; k < 4; k++) step(0, 0, 0, 0, 0, 0, 0, 0, 1, acc);
    endtask

    task automatic rd(input int a, output logic [15:0] val);
        op_valid = 0;
        dbg_addr = a[2:0];
        @(posedge clock);
        @(negedge clock);
        val = dbg_data;
    endtask

    task automatic do_reset();
        op_valid = 0; res_ready = 1; reset = 1;
        @(posedge clock);
        @(negedge clock);
        reset = 0;
        for (int i = 0; i < 8; i++) mr[i] = 0;
        mf = '0;
        pend_q.delete(); done_q.delete(); obs_q.delete();
    endtask

    task automatic test_reset();
        logic [15:0] val;
        do_reset();
        total++;
        if ({res_valid, flag_v, flag_c, flag_n, flag_z, res_illeg, op_ready} !== 7'b0000001 || res_data !== 16'h0) begin
            bad++;
            $display("FAIL reset_state: got rv=%b vcnz=%b%b%b%b il=%b rdy=%b d=%h want rv=0 vcnz=0000 il=0 rdy=1 d=0000",
                     res_valid, flag_v, flag_c, flag_n, flag_z, res_illeg, op_ready, res_data);
        end
        for (int i = 0; i < 8; i++) begin
            rd(i, val);
            total++;
            if (val !== 16'h0) begin bad++; $display("FAIL reset_reg%0d: got %h want 0000", i, val); end
        end
    endtask

    task automatic test_forward();
        bit a0, a1;
        res_t o;
        logic [15:0] val;
        step(1, 15, 1, 0, 0, 1, 1, 'h7FFF, 1, a0);
        step(1, 1, 2, 1, 0, 1, 0, 0, 1, a1);
        drain();
        total++;
        if (!(a0 && a1) || obs_q.size() != 2) begin
            bad++; $display("FAIL fwd_count: got acc=%b%b n=%0d want acc=11 n=2", a0, a1, obs_q.size());
        end else begin
            void'(obs_q.pop_front());
            o = obs_q.pop_front();
            total++;
            if (o.d !== 16'h8000 || o.fl !== 4'b1010 || o.i !== 1'b0) begin
                bad++; $display("FAIL fwd_inc: got d=%h vcnz=%b il=%b want d=8000 vcnz=1010 il=0", o.d, o.fl, o.i);
            end
        end
        rd(2, val);
        total++;
        if (val !== 16'h8000) begin bad++; $display("FAIL fwd_r2: got %h want 8000", val); end
        obs_q.delete(); done_q.delete();
    endtask

    task automatic test_carry_chain();
        bit acc;
        res_t o1, o2;
        step(1, 15, 3, 0, 0, 1, 1, 'h0001, 1, acc);
        step(1, 2, 4, 3, 0, 1, 1, 'hFFFF, 1, acc);
        step(1, 3, 5, 0, 0, 1, 1, 'h0000, 1, acc);
        drain();
        total++;
        if (obs_q.size() != 3) begin
            bad++; $display("FAIL carry_count: got %0d want 3", obs_q.size());
        end else begin
            void'(obs_q.pop_front());
            o1 = obs_q.pop_front();
            o2 = obs_q.pop_front();
            total++;
            if (o1.d !== 16'h0000 || o1.fl !== 4'b0101) begin
                bad++; $display("FAIL carry_add: got d=%h vcnz=%b want d=0000 vcnz=0101", o1.d, o1.fl);
            end
            total++;
            if (o2.d !== 16'h0001 || o2.fl !== 4'b0000) begin
                bad++; $display("FAIL carry_addc: got d=%h vcnz=%b want d=0001 vcnz=0000", o2.d, o2.fl);
            end
        end
        obs_q.delete(); done_q.delete();
    endtask

    task automatic test_backpressure();
        bit a1, a2, a3, acc;
        int k;
        step(1, 15, 1, 0, 0, 1, 1, 'hA1, 0, a1);
        step(1, 15, 2, 0, 0, 1, 1, 'hA2, 0, a2);
        step(1, 15, 3, 0, 0, 1, 1, 'hA3, 0, a3);
        total++;
        if ({a1, a2, a3} !== 3'b110) begin bad++; $display("FAIL bp_ready: got acc=%b%b%b want 110", a1, a2, a3); end
        acc = 0;
        for (k = 0; k < 5 && !acc; k++) step(1, 15, 3, 0, 0, 1, 1, 'hA3, 1, acc);
        total++;
        if (!acc) begin bad++; $display("FAIL bp_timeout: third op not accepted within 5 cycles"); end
        drain();
        total++;
        if (obs_q.size() != 3) begin
            bad++; $display("FAIL bp_count: got %0d want 3", obs_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                total++;
                if (obs_q[i].d !== 16'(16'hA1 + i)) begin
                    bad++; $display("FAIL bp_order%0d: got %h want %h", i, obs_q[i].d, 16'(16'hA1 + i));
                end
            end
        end
        obs_q.delete(); done_q.delete();
    endtask

    task automatic test_illegal();
        bit acc;
        res_t o;
        logic [15:0] val;
        step(1, 4, 6, 0, 0, 1, 1, 'h0001, 1, acc);
        step(1, 20, 1, 2, 3, 1, 0, 0, 1, acc);
        drain();
        total++;
        if (obs_q.size() != 2) begin
            bad++; $display("FAIL ill_count: got %0d want 2", obs_q.size());
        end else begin
            void'(obs_q.pop_front());
            o = obs_q.pop_front();
            total++;
            if (o.i !== 1'b1 || o.d !== 16'h0 || o.fl !== 4'b0010) begin
                bad++; $display("FAIL ill_result: got il=%b d=%h vcnz=%b want il=1 d=0000 vcnz=0010", o.i, o.d, o.fl);
            end
        end
        rd(1, val);
        total++;
        if (val !== 16'h00A1) begin bad++; $display("FAIL ill_r1: got %h want 00a1", val); end
        obs_q.delete(); done_q.delete();
    endtask

    task automatic test_reset_on_retire();
        bit acc;
        logic [15:0] val;
        step(1, 15, 5, 0, 0, 1, 1, 'h1234, 1, acc);
        do_reset();
        total++;
        if (!acc || res_valid !== 1'b0 || op_ready !== 1'b1) begin
            bad++; $display("FAIL rst_retire: got acc=%b rv=%b rdy=%b want acc=1 rv=0 rdy=1", acc, res_valid, op_ready);
        end
        rd(5, val);
        total++;
        if (val !== 16'h0) begin bad++; $display("FAIL rst_r5: got %h want 0000", val); end
    endtask

    task automatic test_random();
        bit acc;
        int imm, s;
        res_t o, e;
        logic [15:0] val;
        int corner[5] = '{0, 1, 'h7FFF, 'h8000, 'hFFFF};
        for (int k = 0; k < 400; k++) begin
            imm = ($urandom % 3 == 0) ? corner[$urandom % 5] : int'($urandom % 65536);
            s = ($urandom % 8 == 0) ? 16 + int'($urandom % 16) : int'($urandom % 16);
            step($urandom % 4 != 0, s, $urandom % 8, $urandom % 8, $urandom % 8,
                 $urandom % 5 != 0, $urandom % 3 == 0, imm, $urandom % 4 != 0, acc);
        end
        drain();
        total++;
        if (pend_q.size() != 0 || obs_q.size() != done_q.size()) begin
            bad++; $display("FAIL rand_count: got pend=%0d obs=%0d want pend=0 obs=%0d", pend_q.size(), obs_q.size(), done_q.size());
        end
        while (obs_q.size() > 0 && done_q.size() > 0) begin
            o = obs_q.pop_front();
            e = done_q.pop_front();
            total++;
            if (o !== e) begin
                bad++; $display("FAIL rand_result: got d=%h il=%b vcnz=%b want d=%h il=%b vcnz=%b", o.d, o.i, o.fl, e.d, e.i, e.fl);
            end
        end
        for (int i = 0; i < 8; i++) begin
            rd(i, val);
            total++;
            if (val !== mr[i][15:0]) begin bad++; $display("FAIL rand_reg%0d: got %h want %h", i, val, mr[i][15:0]); end
        end
    endtask

    initial begin
        @(negedge clock);
        test_reset();
        test_forward();
        test_carry_chain();
        test_backpressure();
        test_illegal();
        test_reset_on_retire();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
